hamming_decoder: RTL and testbench

HAMMING_DECODER -- requirements
Module: hamming_decoder

---
 rtl/hamming_decoder.sv | 166 ++++++++++++++++
 tb/tb_hamming_decoder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder.sv
// ---------------------------------------------------------------------------
// hamming_decoder
//   Two-stage pipelined (7,4) Hamming decoder with valid/ready handshakes on
//   both sides. It also keeps saturating statistics counters.
//   Stage 1 captures the codeword and its syndrome.
//   Stage 2 captures the corrected data, the error flag and the syndrome.
//
// Ports
//   clk        : clock, rising edge active
//   rst_n      : asynchronous active-low reset
//   c[6:0]     : received codeword, bit i is Hamming position i+1
//   in_valid   : c is valid
//   in_ready   : decoder accepts c this cycle (combinational from out_ready)
//   u[3:0]     : decoded data {c6,c5,c4,c2} after correction
//   err        : nonzero syndrome, one bit was corrected
//   syn[2:0]   : syndrome {s4,s2,s1}
//   out_valid  : u/err/syn are valid
//   out_ready  : downstream accepts the output
//   cnt_clr    : synchronous clear of both counters (wins over increment)
//   word_cnt   : delivered words, saturating
//   corr_cnt   : delivered words with err=1, saturating
// ---------------------------------------------------------------------------
module hamming_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       c,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       u,
  output logic             err,
  output logic [2:0]       syn,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] corr_cnt
);

  // Syndrome {s4,s2,s1}. Each check bit covers the positions whose index has
  // that bit set.
  function automatic logic [2:0] f_syndrome(input logic [6:0] cw);
    logic w_s1;
    logic w_s2;
    logic w_s4;
    w_s1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    w_s2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    w_s4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    return {w_s4, w_s2, w_s1};
  endfunction

  // Flip the bit named by the syndrome. Then extract the data positions.
  function automatic logic [3:0] f_correct(input logic [6:0] cw, input logic [2:0] s);
    logic [6:0] w_fix;
    w_fix = cw;
    case (s)
      3'd1:    w_fix[0] = ~cw[0];
      3'd2:    w_fix[1] = ~cw[1];
      3'd3:    w_fix[2] = ~cw[2];
      3'd4:    w_fix[3] = ~cw[3];
      3'd5:    w_fix[4] = ~cw[4];
      3'd6:    w_fix[5] = ~cw[5];
      3'd7:    w_fix[6] = ~cw[6];
      default: w_fix = cw;
    endcase
    return {w_fix[6], w_fix[5], w_fix[4], w_fix[2]};
  endfunction

  logic             r_s1_valid;
  logic [6:0]       r_s1_c;
  logic [2:0]       r_s1_syn;
  logic             r_out_valid;
  logic [3:0]       r_u;
  logic             r_err;
  logic [2:0]       r_syn;
  logic [CNT_W-1:0] r_word_cnt;
  logic [CNT_W-1:0] r_corr_cnt;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_out_xfer;
  logic [2:0]       w_syn_in;
  logic [3:0]       w_u_fix;
  logic             w_word_inc;
  logic             w_corr_inc;

  // A stage advances when its downstream slot is empty or draining this cycle.
  assign w_adv2     = !r_out_valid || out_ready;
  assign w_adv1     = !r_s1_valid || w_adv2;
  assign w_out_xfer = r_out_valid && out_ready;
  assign w_syn_in   = f_syndrome(c);
  assign w_u_fix    = f_correct(r_s1_c, r_s1_syn);

  // Counter increment enables. A counter that is all ones holds, so it never wraps.
  always_comb begin
    w_word_inc = 1'b0;
    w_corr_inc = 1'b0;
    if (w_out_xfer) begin
      w_word_inc = ~(&r_word_cnt);
      w_corr_inc = r_err && ~(&r_corr_cnt);
    end else begin
      w_word_inc = 1'b0;
      w_corr_inc = 1'b0;
    end
  end

  // Stage 1: capture the codeword and its syndrome. Take a bubble when no input is offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_c     <= 7'd0;
      r_s1_syn   <= 3'd0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_c   <= c;
        r_s1_syn <= w_syn_in;
      end
    end
  end

  // Stage 2: capture the corrected data. Hold it while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_u         <= 4'd0;
      r_err       <= 1'b0;
      r_syn       <= 3'd0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_u   <= w_u_fix;
        r_err <= (r_s1_syn != 3'd0);
        r_syn <= r_s1_syn;
      end
    end
  end

  // Statistics counters. A clear wins over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= {CNT_W{1'b0}};
      r_corr_cnt <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      r_word_cnt <= {CNT_W{1'b0}};
      r_corr_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_word_inc) begin
        r_word_cnt <= r_word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_corr_inc) begin
        r_corr_cnt <= r_corr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign in_ready  = w_adv1;
  assign out_valid = r_out_valid;
  assign u         = r_u;
  assign err       = r_err;
  assign syn       = r_syn;
  assign word_cnt  = r_word_cnt;
  assign corr_cnt  = r_corr_cnt;

endmodule

// File: tb/tb_hamming_decoder.sv
// ---------------------------------------------------------------------------
// tb_hamming_decoder
//   Bench for hamming_decoder. It uses a table of known vectors, a full
//   data/error sweep, random handshake traffic checked against a reference
//   decoder and a scoreboard, counter saturation and clear, and a reset taken
//   while words are in flight. A second instance with CNT_W=4 shares every
//   input so that counter saturation is reachable.
// ---------------------------------------------------------------------------
module tb_hamming_decoder;

  logic        clk;
  logic        rst_n;
  logic [6:0]  c;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  u;
  logic        err;
  logic [2:0]  syn;
  logic        out_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [15:0] word_cnt;
  logic [15:0] corr_cnt;
  logic        in_ready4;
  logic [3:0]  u4;
  logic        err4;
  logic [2:0]  syn4;
  logic        out_valid4;
  logic [3:0]  word_cnt4;
  logic [3:0]  corr_cnt4;

  hamming_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .c(c), .in_valid(in_valid), .in_ready(in_ready),
    .u(u), .err(err), .syn(syn), .out_valid(out_valid), .out_ready(out_ready),
    .cnt_clr(cnt_clr), .word_cnt(word_cnt), .corr_cnt(corr_cnt));

  hamming_decoder #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .c(c), .in_valid(in_valid), .in_ready(in_ready4),
    .u(u4), .err(err4), .syn(syn4), .out_valid(out_valid4), .out_ready(out_ready),
    .cnt_clr(cnt_clr), .word_cnt(word_cnt4), .corr_cnt(corr_cnt4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] u;
    logic [2:0] syn;
    logic       err;
  } exp_t;

  typedef struct {
    logic [6:0] cw;
    logic [3:0] u;
    logic [2:0] syn;
    logic       err;
  } vec_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   m_word = 0;
  int   m_corr = 0;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_u;
  logic       prev_err;
  logic [2:0] prev_syn;
  logic       have_exp = 1'b0;
  exp_t       tab_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference model. The syndrome is the XOR of the positions of all set bits.
  function automatic exp_t ref_decode(input logic [6:0] cw);
    exp_t       r;
    int         s;
    logic [6:0] fx;
    s = 0;
    for (int i = 0; i < 7; i++) if (cw[i]) s = s ^ (i + 1);
    fx = cw;
    if (s != 0) fx[s-1] = ~fx[s-1];
    r.u   = {fx[6], fx[5], fx[4], fx[2]};
    r.syn = s[2:0];
    r.err = (s != 0);
    return r;
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Run one clock cycle. Call at a negedge with the inputs already driven.
  task automatic step();
    exp_t e;
    logic oxfer, ixfer, exp_rdy, popped;
    popped = 1'b0;
    chk("word_cnt16", {16'd0, word_cnt}, sat(m_word, 65535));
    chk("corr_cnt16", {16'd0, corr_cnt}, sat(m_corr, 65535));
    chk("word_cnt4", {28'd0, word_cnt4}, sat(m_word, 15));
    chk("corr_cnt4", {28'd0, corr_cnt4}, sat(m_corr, 15));
    if (prev_stall) begin
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_u", {28'd0, u}, {28'd0, prev_u});
      chk("hold_err", {31'd0, err}, {31'd0, prev_err});
      chk("hold_syn", {29'd0, syn}, {29'd0, prev_syn});
    end
    #1;
    exp_rdy = !(q.size() == 2 && !out_ready);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("in_ready4", {31'd0, in_ready4}, {31'd0, exp_rdy});
    oxfer = out_valid && out_ready;
    ixfer = in_valid && in_ready;
    chk("spurious_out", {31'd0, (out_valid && q.size() == 0)}, 32'd0);
    if (oxfer && q.size() > 0) begin
      e = q.pop_front();
      popped = 1'b1;
      chk("u", {28'd0, u}, {28'd0, e.u});
      chk("syn", {29'd0, syn}, {29'd0, e.syn});
      chk("err", {31'd0, err}, {31'd0, e.err});
      chk("u4", {28'd0, u4}, {28'd0, e.u});
      chk("valid4", {31'd0, out_valid4}, 32'd1);
    end
    if (ixfer) q.push_back(have_exp ? tab_exp : ref_decode(c));
    prev_stall = out_valid && !out_ready;
    prev_u = u;
    prev_err = err;
    prev_syn = syn;
    @(posedge clk);
    if (cnt_clr) begin
      m_word = 0;
      m_corr = 0;
    end else if (popped) begin
      m_word++;
      if (e.err) m_corr++;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    have_exp = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) step();
    step();
    chk("drain_empty", q.size(), 32'd0);
  endtask

  vec_t tab[7];

  initial begin
    tab[0] = '{7'b1010101, 4'b1011, 3'd0, 1'b0};  // clean word
    tab[1] = '{7'b1000101, 4'b1011, 3'd5, 1'b1};  // c4 flipped
    tab[2] = '{7'b1010110, 4'b1010, 3'd3, 1'b1};  // c0,c1 flipped: miscorrect c2
    tab[3] = '{7'b1011101, 4'b1011, 3'd4, 1'b1};  // parity bit c3 flipped
    tab[4] = '{7'b0000000, 4'b0000, 3'd0, 1'b0};
    tab[5] = '{7'b1111111, 4'b1111, 3'd0, 1'b0};
    tab[6] = '{7'b0111111, 4'b1111, 3'd7, 1'b1};  // c6 flipped

    rst_n = 1'b0; c = 7'd0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_u", {28'd0, u}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_syn", {29'd0, syn}, 32'd0);
    chk("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
    chk("rst_corr_cnt", {16'd0, corr_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First word: out_valid shows up after the second rising edge.
    in_valid = 1'b1; c = tab[0].cw; out_ready = 1'b1;
    have_exp = 1'b1; tab_exp = '{tab[0].u, tab[0].syn, tab[0].err};
    step();
    in_valid = 1'b0;
    chk("lat_edge1", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_edge2", {31'd0, out_valid}, 32'd1);
    drain();
    chk("first_word_cnt", {16'd0, word_cnt}, 32'd1);
    chk("first_corr_cnt", {16'd0, corr_cnt}, 32'd0);

    // Table of known vectors, streamed back to back.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; c = tab[i].cw; out_ready = 1'b1;
      have_exp = 1'b1; tab_exp = '{tab[i].u, tab[i].syn, tab[i].err};
      step();
    end
    drain();

    // Sweep: 16 data values x {no error, each single-bit flip}.
    for (int d = 0; d < 16; d++) begin
      for (int e = 0; e < 8; e++) begin
        logic [6:0] cw;
        logic [3:0] dv;
        dv = d[3:0];
        cw = encode(dv);
        if (e != 0) cw[e-1] = ~cw[e-1];
        in_valid = 1'b1; c = cw; out_ready = 1'b1;
        have_exp = 1'b1; tab_exp = '{dv, e[2:0], (e != 0)};
        step();
      end
    end
    drain();

    // Random traffic with random valid and ready.
    have_exp = 1'b0;
    for (int k = 0; k < 300; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      c = 7'($urandom_range(0, 127));
      out_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    drain();

    // Backpressure: 10 words with out_ready toggled at random.
    begin
      int sent;
      sent = 0;
      for (int k = 0; k < 200 && sent < 10; k++) begin
        in_valid = 1'b1;
        c = 7'($urandom_range(0, 127));
        out_ready = ($urandom_range(0, 1) == 1);
        if (in_ready) sent++;
        step();
      end
      chk("bp_sent", sent, 32'd10);
    end
    drain();

    // Counters: clear, then 20 erroneous words saturate the 4-bit instance.
    in_valid = 1'b0; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      logic [6:0] cw;
      cw = encode(4'($urandom_range(0, 15)));
      cw[k % 7] = ~cw[k % 7];
      in_valid = 1'b1; c = cw; out_ready = 1'b1;
      step();
    end
    drain();
    chk("sat_word4", {28'd0, word_cnt4}, 32'd15);
    chk("sat_corr4", {28'd0, corr_cnt4}, 32'd15);
    chk("word16_20", {16'd0, word_cnt}, 32'd20);

    // Clear on a cycle that also carries an output transfer.
    in_valid = 1'b1; c = 7'b1000101; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("clr_pre_valid", {31'd0, out_valid}, 32'd1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_word16", {16'd0, word_cnt}, 32'd0);
    chk("clr_corr16", {16'd0, corr_cnt}, 32'd0);
    chk("clr_word4", {28'd0, word_cnt4}, 32'd0);
    drain();

    // Build up some counts, then reset with two words in flight.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; c = 7'b1000101; out_ready = 1'b1;
      step();
    end
    drain();
    in_valid = 1'b1; c = 7'b0111111; out_ready = 1'b1;
    step();
    c = 7'b1010110;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_word", {16'd0, word_cnt}, 32'd0);
    chk("mid_rst_corr", {16'd0, corr_cnt}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    m_word = 0;
    m_corr = 0;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    // Normal operation resumes after reset.
    in_valid = 1'b1; c = tab[1].cw; out_ready = 1'b1;
    have_exp = 1'b1; tab_exp = '{tab[1].u, tab[1].syn, tab[1].err};
    step();
    drain();
    chk("post_rst_word", {16'd0, word_cnt}, 32'd1);
    chk("post_rst_corr", {16'd0, corr_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
